// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// Parallel-to-serial transmitter. A single-cycle load strobe latches a payload,
// which is then sent on one serial line as a frame: one start bit (0), DATA_WIDTH
// data bits LSB first, and one stop bit (1). Each bit is held on the line for
// CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit on tx (>= 1)
//   DATA_WIDTH    payload bits per frame
//
// Ports:
//   clock  in   rising-edge clock for all state
//   reset  in   synchronous, active-high; overrides every other input
//   data   in   payload, sampled only on the accepting edge
//   load   in   start strobe, level-sampled while idle
//   tx     out  serial line (idle/stop = 1, start = 0), registered
//   busy   out  high while a frame is in progress, registered
//   done   out  one-cycle pulse when a frame completes, registered
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  load,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    // Counter widths are kept at least one bit so CLKS_PER_BIT=1 and
    // DATA_WIDTH=1 still elaborate.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  bit_end;
    logic [DATA_WIDTH-1:0] shift_d;

    // Last cycle of the current bit time.
    assign bit_end = (cnt_q == CNT_LAST);
    // Payload after dropping the bit just sent; its LSB is the next data bit.
    assign shift_d = shift_q >> 1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    // The done cycle is spent here, so a held load restarts
                    // one cycle after the stop bit ends.
                    if (load) begin
                        shift_q <= data;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q <= shift_d;
                            idx_q   <= idx_q + 1'b1;
                            tx_q    <= shift_d[0];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
// Scoreboard bench for serial_tx. Two instances share the clock: dut0 uses the
// defaults (4 clocks/bit), dut1 uses 1 clock/bit. Stimulus pushes one expected
// frame (payload, accepting edge, optional abort point) per accepted load; a
// monitor samples each instance on the falling edge, checks idle cycles, and
// when busy rises pops the next expected frame and checks it cycle by cycle.
// -----------------------------------------------------------------------------
module tb_serial_tx;

    typedef struct {
        logic [7:0] d;
        int         start_cyc;
        int         abort_k;
    } exp_t;

    logic       clk;
    logic       rst0, load0, rst1, load1;
    logic [7:0] data0, data1;
    logic       tx0, busy0, done0, tx1, busy1, done1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    bit   in_frame [2];
    int   kk       [2];
    exp_t cur      [2];

    serial_tx #(.CLKS_PER_BIT(4), .DATA_WIDTH(8)) dut0 (
        .clock(clk), .reset(rst0), .data(data0), .load(load0),
        .tx(tx0), .busy(busy0), .done(done0)
    );

    serial_tx #(.CLKS_PER_BIT(1), .DATA_WIDTH(8)) dut1 (
        .clock(clk), .reset(rst1), .data(data1), .load(load1),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int id, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s cyc=%0d actual=%0h expected=%0h",
                     id, name, cyc, act, exp);
        end
    endtask

    task automatic mon_step(input int id, input int cpb,
                            input logic tx_v, input logic busy_v, input logic done_v);
        int   n;
        int   bi;
        logic eb;
        n = 10 * cpb;
        if (!in_frame[id]) begin
            if (!busy_v) begin
                chk(id, "idle_tx", 32'(tx_v), 32'd1);
                chk(id, "idle_done", 32'(done_v), 32'd0);
                return;
            end
            in_frame[id] = 1'b1;
            kk[id] = 0;
            if (id == 0 && q0.size() > 0) begin
                cur[0] = q0.pop_front();
            end else if (id == 1 && q1.size() > 0) begin
                cur[1] = q1.pop_front();
            end else begin
                chk(id, "unexpected_frame", 32'd1, 32'd0);
                cur[id].d = 8'h00;
                cur[id].start_cyc = cyc;
                cur[id].abort_k = -1;
            end
            chk(id, "start_cycle", 32'(cyc), 32'(cur[id].start_cyc));
        end
        if (kk[id] == cur[id].abort_k) begin
            chk(id, "abort_busy", 32'(busy_v), 32'd0);
            chk(id, "abort_tx", 32'(tx_v), 32'd1);
            chk(id, "abort_done", 32'(done_v), 32'd0);
            $display("dut%0d frame data=%02h aborted at k=%0d", id, cur[id].d, kk[id]);
            in_frame[id] = 1'b0;
        end else if (kk[id] < n) begin
            bi = kk[id] / cpb;
            if (bi == 0)      eb = 1'b0;
            else if (bi <= 8) eb = cur[id].d[bi-1];
            else              eb = 1'b1;
            chk(id, "frame_tx", 32'(tx_v), 32'(eb));
            chk(id, "frame_busy", 32'(busy_v), 32'd1);
            chk(id, "frame_done", 32'(done_v), 32'd0);
            kk[id]++;
        end else begin
            chk(id, "end_busy", 32'(busy_v), 32'd0);
            chk(id, "end_done", 32'(done_v), 32'd1);
            chk(id, "end_tx", 32'(tx_v), 32'd1);
            $display("dut%0d frame data=%02h start=%0d done=%0d",
                     id, cur[id].d, cur[id].start_cyc, cyc);
            in_frame[id] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, 4, tx0, busy0, done0);
            mon_step(1, 1, tx1, busy1, done1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push0(input logic [7:0] d, input int s, input int ab);
        exp_t e;
        e.d = d; e.start_cyc = s; e.abort_k = ab;
        q0.push_back(e);
    endtask

    initial begin
        int e0;
        int guard;
        in_frame[0] = 1'b0; in_frame[1] = 1'b0;
        kk[0] = 0; kk[1] = 0;

        // Reset held 3 edges with load high and data all ones: no frame.
        rst0 = 1'b1; load0 = 1'b1; data0 = 8'hFF;
        rst1 = 1'b1; load1 = 1'b1; data1 = 8'hFF;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        rst0 = 1'b0; load0 = 1'b0;
        rst1 = 1'b0; load1 = 1'b0;
        repeat (5) tick();

        // Single frame 8'hA5.
        data0 = 8'hA5; load0 = 1'b1; e0 = cyc + 1;
        push0(8'hA5, e0, -1);
        tick();
        load0 = 1'b0;
        wait_until(e0 + 45);

        // Load while busy is ignored; late data changes are ignored.
        data0 = 8'h3C; load0 = 1'b1; e0 = cyc + 1;
        push0(8'h3C, e0, -1);
        tick();
        load0 = 1'b0;
        wait_until(e0 + 9);
        data0 = 8'hFF; load0 = 1'b1;
        tick();
        load0 = 1'b0;
        wait_until(e0 + 19);
        data0 = 8'h5A;
        wait_until(e0 + 45);

        // Back-to-back with load held: second accept at E0+41.
        data0 = 8'h01; load0 = 1'b1; e0 = cyc + 1;
        push0(8'h01, e0, -1);
        push0(8'h01, e0 + 41, -1);
        wait_until(e0 + 41);
        load0 = 1'b0;
        wait_until(e0 + 90);

        // Reset sampled at E0+15 aborts the frame, then a clean 8'h80 frame.
        data0 = 8'h00; load0 = 1'b1; e0 = cyc + 1;
        push0(8'h00, e0, 15);
        tick();
        load0 = 1'b0;
        wait_until(e0 + 14);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        repeat (4) tick();
        data0 = 8'h80; load0 = 1'b1; e0 = cyc + 1;
        push0(8'h80, e0, -1);
        tick();
        load0 = 1'b0;
        wait_until(e0 + 45);

        // One clock per bit: 8'hC3 as a 10-cycle frame.
        begin
            exp_t e;
            data1 = 8'hC3; load1 = 1'b1; e0 = cyc + 1;
            e.d = 8'hC3; e.start_cyc = e0; e.abort_k = -1;
            q1.push_back(e);
        end
        tick();
        load1 = 1'b0;
        wait_until(e0 + 15);

        // Everything expected must have been seen.
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0 || in_frame[0] || in_frame[1])
               && guard < 200) begin
            tick();
            guard++;
        end
        chk(0, "drain_pending", 32'(q0.size() + q1.size()), 32'd0);
        chk(0, "drain_in_frame", 32'(int'(in_frame[0]) + int'(in_frame[1])), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
